room_transition_ctrl: RTL and testbench
=======================================

Name: room_transition_ctrl

Overview:
Sequences a room change when the player touches a door. Detects the door hit and freezes gameplay, then fades the screen out. Next it hands a single-frame doorcode to the room state machine and kicks the room tile loader, then fades back in. Sits between player/door collision logic and the room state machine, tile loader and colour mapper; all timing is in frames via a one-cycle frame_tick strobe.

Parameters:
COOLDOWN_FRAMES, 30, frames after fade-in during which door hits are ignored (range 1..63)
LOAD_TIMEOUT, 60, frames to wait for load_done before forcing fade-in (range 1..63)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-Clk pulse per frame (vsync edge), synchronous to Clk
door_hit  input  3  raw door collision code: 0 none, 1 left, 2 right, 3 top, 4 bottom, 5-7 invalid
load_done  input  1  tile loader finished (level, sampled only in LOAD)
doorcode_out  output  3  doorcode to room state machine; nonzero for exactly one frame per transition
load_start  output  1  one-Clk pulse to start tile loader
freeze  output  1  halts player/enemy movement
fade_level  output  4  screen brightness, 15 = full, 0 = black
spawn_side  output  3  door the player appears at in the new room (opposite of entered door)
busy  output  1  high whenever state != IDLE
load_err  output  1  sticky: a load timed out; cleared only by Reset

Behaviour:
- All state registered on posedge Clk; Reset has priority over every other event, including a simultaneous frame_tick.
- Reset values: state IDLE, doorcode_out 0, load_start 0, freeze 0, fade_level 15, spawn_side 0, busy 0, load_err 0, all counters 0.
- States: IDLE, FADE_OUT, COMMIT, LOAD, FADE_IN, COOLDOWN.
- Events advance only on cycles with frame_tick=1, except LOAD completion, which is sampled every Clk.
- IDLE: on frame_tick with door_hit in 1..4, latch door_q <= door_hit.
  - spawn_side <= opposite (1<->2, 3<->4); freeze <= 1; go FADE_OUT.
  - door_hit 0 or 5..7: stay IDLE, no output change.
- FADE_OUT: each frame_tick, fade_level decrements by 1. On the tick where it becomes 0, go COMMIT (15 ticks from 15).
- COMMIT: doorcode_out = door_q from entry until the next frame_tick.
  - On that tick: doorcode_out <= 0, load_start pulses exactly one Clk, frame counter cleared, go LOAD.
  - Guarantees a vsync-clocked consumer samples the code exactly once.
- LOAD: load_done=1 goes to FADE_IN on the next Clk. Otherwise each frame_tick increments the counter.
  - When the counter reaches LOAD_TIMEOUT: load_err <= 1, go FADE_IN.
  - load_done and timeout on the same cycle: load_done wins, load_err unchanged.
- FADE_IN: each frame_tick, fade_level increments by 1. On reaching 15: freeze <= 0, counter cleared, go COOLDOWN.
- COOLDOWN: door_hit ignored. After COOLDOWN_FRAMES frame_ticks, go IDLE.
  - spawn_side holds its value until the next transition latch.
- fade_level saturates: never below 0 or above 15.
- busy is combinational from state.
- Reset mid-sequence: immediate return to reset values; no load_start or doorcode_out is emitted afterwards.

Optional Feature:
- Macro ROOM_FADE_EN.
- Defined: full fade sequencing as above.
- Undefined:
  - FADE_OUT and FADE_IN are never entered; fade_level is constant 15.
  - IDLE on a valid hit goes directly to COMMIT with freeze=1.
  - LOAD exits directly to COOLDOWN, with freeze <= 0 on that transition.
  - All other timing is unchanged.

Test Plan:
- Normal transition: frame_tick every 10 Clk; door_hit=2 on a tick; load_done after 3 frames.
  - freeze=1; fade_level 15->0 over 15 ticks; doorcode_out=2 for exactly one frame; single load_start pulse; spawn_side=1.
  - Then fade 0->15 over 15 ticks, freeze=0, busy=0 exactly 30 ticks later, load_err=0.
- Load timeout: door_hit=3, load_done held 0.
  - After 60 frame_ticks in LOAD, load_err=1 and fade-in starts; spawn_side=4.
  - load_err stays 1 through a subsequent good transition until Reset.
- Invalid/ignored codes: door_hit=5 in IDLE -> no state change, busy=0.
  - door_hit=1 held throughout COOLDOWN -> no new transition until IDLE; then one transition starts on the next tick.
- Reset mid-operation: assert Reset during FADE_OUT at fade_level=7, coincident with frame_tick.
  - Next cycle: state IDLE, fade_level=15, freeze=0, doorcode_out=0; no load_start seen.
- Simultaneous LOAD events: load_done=1 on the same cycle the timeout count is reached -> FADE_IN, load_err=0.
- ROOM_FADE_EN undefined: door_hit=4 -> doorcode_out=4 for one frame starting the cycle after the detecting tick.
  - fade_level stays 15 throughout; spawn_side=3; freeze drops on load_done.

Source files
------------

// File: rtl/room_transition_ctrl_if.sv
// Bundles the door/loader/fade signals exchanged between room_transition_ctrl (slave)
// and the surrounding game logic (master).
interface room_transition_ctrl_if;
  logic       frame_tick;
  logic [2:0] door_hit;
  logic       load_done;
  logic [2:0] doorcode_out;
  logic       load_start;
  logic       freeze;
  logic [3:0] fade_level;
  logic [2:0] spawn_side;
  logic       busy;
  logic       load_err;

  modport master (
    output frame_tick, door_hit, load_done,
    input  doorcode_out, load_start, freeze, fade_level, spawn_side, busy, load_err
  );

  modport slave (
    input  frame_tick, door_hit, load_done,
    output doorcode_out, load_start, freeze, fade_level, spawn_side, busy, load_err
  );
endinterface

// File: rtl/room_transition_ctrl.sv
// Room-change sequencer: door hit -> freeze/fade out -> one-frame doorcode + loader kick -> fade in.
// Define ROOM_FADE_EN to enable fade sequencing; otherwise fade_level stays at full brightness.
module room_transition_ctrl #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned LOAD_TIMEOUT    = 60
) (
  input  logic                 Clk,
  input  logic                 Reset,
  room_transition_ctrl_if.slave rt
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned FADE_W = 4;

  typedef enum logic [2:0] {
    IDLE, FADE_OUT, COMMIT, LOAD, FADE_IN, COOLDOWN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [2:0]         doorcode_q;
  logic               load_start_q;
  logic               freeze_q;
  logic [FADE_W-1:0]  fade_q;
  logic [2:0]         spawn_q;
  logic               load_err_q;
`ifdef ROOM_FADE_EN
  logic [2:0]         door_q;
`endif

  logic             valid_hit;
  logic [CNT_W-1:0] cnt_next;
  logic             load_timeout;

  assign valid_hit    = (rt.door_hit >= 3'd1) && (rt.door_hit <= 3'd4);
  assign cnt_next     = frame_cnt + CNT_W'(1);
  assign load_timeout = rt.frame_tick && (cnt_next == CNT_W'(LOAD_TIMEOUT));

  // Player reappears at the door opposite to the one entered.
  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'd1:    opposite = 3'd2;
      3'd2:    opposite = 3'd1;
      3'd3:    opposite = 3'd4;
      3'd4:    opposite = 3'd3;
      default: opposite = 3'd0;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      frame_cnt    <= '0;
      doorcode_q   <= 3'd0;
      load_start_q <= 1'b0;
      freeze_q     <= 1'b0;
      fade_q       <= 4'd15;
      spawn_q      <= 3'd0;
      load_err_q   <= 1'b0;
`ifdef ROOM_FADE_EN
      door_q       <= 3'd0;
`endif
    end else begin
      load_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rt.frame_tick && valid_hit) begin
            spawn_q  <= opposite(rt.door_hit);
            freeze_q <= 1'b1;
`ifdef ROOM_FADE_EN
            door_q   <= rt.door_hit;
            state    <= FADE_OUT;
`else
            doorcode_q <= rt.door_hit;
            state      <= COMMIT;
`endif
          end
        end
`ifdef ROOM_FADE_EN
        FADE_OUT: begin
          if (rt.frame_tick) begin
            if (fade_q != 4'd0) fade_q <= fade_q - 4'd1;
            if (fade_q <= 4'd1) begin
              doorcode_q <= door_q;
              state      <= COMMIT;
            end
          end
        end
`endif
        // Code is held for a whole frame so a vsync-clocked consumer sees it exactly once.
        COMMIT: begin
          if (rt.frame_tick) begin
            doorcode_q   <= 3'd0;
            load_start_q <= 1'b1;
            frame_cnt    <= '0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (rt.load_done || load_timeout) begin
            if (!rt.load_done) load_err_q <= 1'b1;
`ifdef ROOM_FADE_EN
            state     <= FADE_IN;
`else
            freeze_q  <= 1'b0;
            frame_cnt <= '0;
            state     <= COOLDOWN;
`endif
          end else if (rt.frame_tick) begin
            frame_cnt <= cnt_next;
          end
        end
`ifdef ROOM_FADE_EN
        FADE_IN: begin
          if (rt.frame_tick) begin
            if (fade_q != 4'd15) fade_q <= fade_q + 4'd1;
            if (fade_q >= 4'd14) begin
              freeze_q  <= 1'b0;
              frame_cnt <= '0;
              state     <= COOLDOWN;
            end
          end
        end
`endif
        COOLDOWN: begin
          if (rt.frame_tick) begin
            if (cnt_next == CNT_W'(COOLDOWN_FRAMES)) begin
              frame_cnt <= '0;
              state     <= IDLE;
            end else begin
              frame_cnt <= cnt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rt.doorcode_out = doorcode_q;
  assign rt.load_start   = load_start_q;
  assign rt.freeze       = freeze_q;
  assign rt.fade_level   = fade_q;
  assign rt.spawn_side   = spawn_q;
  assign rt.load_err     = load_err_q;
  assign rt.busy         = (state != IDLE);

endmodule

// File: tb/tb_room_transition_ctrl.sv
// Directed bench for room_transition_ctrl; expectations follow ROOM_FADE_EN when it is defined.
module tb_room_transition_ctrl;

`ifdef ROOM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  room_transition_ctrl_if rt();

  room_transition_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .rt    (rt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ls_count = 0;
  int dc_count = 0;

  // Count load_start pulses and cycles with a nonzero doorcode.
  always @(posedge Clk) begin
    if (rt.load_start) ls_count <= ls_count + 1;
    if (rt.doorcode_out != 3'd0) dc_count <= dc_count + 1;
  end

  typedef struct {
    logic [2:0] dh;
    logic       ft;
    logic [2:0] e_dc;
    logic       e_busy;
    logic       e_freeze;
    logic [2:0] e_spawn;
    logic [3:0] e_fade;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input logic ft);
    rt.frame_tick = ft;
    @(posedge Clk);
    #1;
    rt.frame_tick = 1'b0;
  endtask

  task automatic frame();
    repeat (9) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    Reset = 1'b0;
  endtask

  // From the latch tick through COMMIT and the load_start pulse.
  task automatic run_to_load(input int door);
    int ls0;
    int dc0;
    ls0 = ls_count;
    dc0 = dc_count;
`ifdef ROOM_FADE_EN
    for (int i = 1; i <= 15; i++) begin
      frame();
      check($sformatf("fade_out_%0d", i), int'(rt.fade_level), 15 - i);
    end
`endif
    check("commit_code", int'(rt.doorcode_out), door);
    repeat (9) cyc(1'b0);
    check("code_hold", int'(rt.doorcode_out), door);
    check("no_early_start", ls_count - ls0, 0);
    cyc(1'b1);
    check("code_clear", int'(rt.doorcode_out), 0);
    check("load_start_hi", int'(rt.load_start), 1);
    cyc(1'b0);
    check("load_start_lo", int'(rt.load_start), 0);
    check("code_cycles", dc_count - dc0, 10);
    check("start_count", ls_count - ls0, 1);
  endtask

  // From LOAD exit through fade-in (if any) and the cooldown.
  task automatic fade_in_cool();
`ifdef ROOM_FADE_EN
    for (int i = 1; i <= 15; i++) begin
      frame();
      check($sformatf("fade_in_%0d", i), int'(rt.fade_level), i);
    end
    check("unfreeze", int'(rt.freeze), 0);
`endif
    repeat (29) frame();
    check("cooldown_busy", int'(rt.busy), 1);
    frame();
    check("idle_after_cool", int'(rt.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ls0;
    logic [2:0] dc_latch;
    dc_latch = FADE ? 3'd0 : 3'd2;

    rt.frame_tick = 1'b0;
    rt.door_hit   = 3'd0;
    rt.load_done  = 1'b0;
    Reset         = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    check("rst_busy",  int'(rt.busy), 0);
    check("rst_freeze", int'(rt.freeze), 0);
    check("rst_fade",  int'(rt.fade_level), 15);
    check("rst_code",  int'(rt.doorcode_out), 0);
    check("rst_spawn", int'(rt.spawn_side), 0);
    check("rst_err",   int'(rt.load_err), 0);
    check("rst_start", int'(rt.load_start), 0);
    Reset = 1'b0;

    // Invalid codes, no-tick hit, then a valid latch of door 2.
    vecs[0] = '{3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 4'd15};
    vecs[1] = '{3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 4'd15};
    vecs[2] = '{3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 4'd15};
    vecs[3] = '{3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd15};
    vecs[4] = '{3'd2, 1'b1, dc_latch, 1'b1, 1'b1, 3'd1, 4'd15};
    for (int i = 0; i < 5; i++) begin
      rt.door_hit = vecs[i].dh;
      cyc(vecs[i].ft);
      check($sformatf("vec%0d_code", i),   int'(rt.doorcode_out), int'(vecs[i].e_dc));
      check($sformatf("vec%0d_busy", i),   int'(rt.busy),         int'(vecs[i].e_busy));
      check($sformatf("vec%0d_freeze", i), int'(rt.freeze),       int'(vecs[i].e_freeze));
      check($sformatf("vec%0d_spawn", i),  int'(rt.spawn_side),   int'(vecs[i].e_spawn));
      check($sformatf("vec%0d_fade", i),   int'(rt.fade_level),   int'(vecs[i].e_fade));
    end
    rt.door_hit = 3'd0;

    // Normal transition, load_done after 3 frames.
    run_to_load(2);
    repeat (3) frame();
    rt.load_done = 1'b1;
    cyc(1'b0);
    rt.load_done = 1'b0;
    check("done_busy",   int'(rt.busy), 1);
    check("done_freeze", int'(rt.freeze), FADE ? 1 : 0);
    check("done_fade",   int'(rt.fade_level), FADE ? 0 : 15);
    fade_in_cool();
    check("normal_err",  int'(rt.load_err), 0);
    check("normal_spawn_hold", int'(rt.spawn_side), 1);

    // Load timeout on door 3.
    rt.door_hit = 3'd3;
    frame();
    rt.door_hit = 3'd0;
    check("to_spawn", int'(rt.spawn_side), 4);
    run_to_load(3);
    repeat (59) frame();
    check("to_err_early", int'(rt.load_err), 0);
    check("to_busy_early", int'(rt.busy), 1);
    frame();
    check("to_err", int'(rt.load_err), 1);
    check("to_freeze", int'(rt.freeze), FADE ? 1 : 0);
    fade_in_cool();
    check("to_err_sticky", int'(rt.load_err), 1);

    // Good transition keeps load_err; door 1 held through cooldown is ignored.
    rt.door_hit = 3'd1;
    frame();
    rt.door_hit = 3'd0;
    check("good_spawn", int'(rt.spawn_side), 2);
    run_to_load(1);
    frame();
    rt.load_done = 1'b1;
    cyc(1'b0);
    rt.load_done = 1'b0;
    rt.door_hit = 3'd1;
    fade_in_cool();
    check("err_kept", int'(rt.load_err), 1);
    frame();
    check("retrigger_busy", int'(rt.busy), 1);
    check("retrigger_spawn", int'(rt.spawn_side), 2);
    rt.door_hit = 3'd0;
    do_reset();
    check("err_cleared", int'(rt.load_err), 0);
    check("reset_busy", int'(rt.busy), 0);

    // Reset mid-sequence, coincident with frame_tick.
    rt.door_hit = 3'd4;
    frame();
    rt.door_hit = 3'd0;
    check("d4_spawn", int'(rt.spawn_side), 3);
    check("d4_code", int'(rt.doorcode_out), FADE ? 0 : 4);
    check("d4_fade", int'(rt.fade_level), 15);
`ifdef ROOM_FADE_EN
    repeat (8) frame();
    check("mid_fade", int'(rt.fade_level), 7);
`endif
    ls0 = ls_count;
    repeat (9) cyc(1'b0);
    Reset = 1'b1;
    cyc(1'b1);
    check("mid_rst_busy",   int'(rt.busy), 0);
    check("mid_rst_fade",   int'(rt.fade_level), 15);
    check("mid_rst_freeze", int'(rt.freeze), 0);
    check("mid_rst_code",   int'(rt.doorcode_out), 0);
    Reset = 1'b0;
    repeat (3) frame();
    check("mid_rst_no_start", ls_count - ls0, 0);
    check("mid_rst_idle", int'(rt.busy), 0);

    // load_done on the same cycle the timeout is reached.
    rt.door_hit = 3'd1;
    frame();
    rt.door_hit = 3'd0;
    run_to_load(1);
    repeat (59) frame();
    repeat (9) cyc(1'b0);
    rt.load_done = 1'b1;
    cyc(1'b1);
    rt.load_done = 1'b0;
    check("sim_err", int'(rt.load_err), 0);
    check("sim_busy", int'(rt.busy), 1);
    check("sim_freeze", int'(rt.freeze), FADE ? 1 : 0);
    fade_in_cool();
    check("sim_err_final", int'(rt.load_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
